// File: rtl/ksa28_share_ctrl_if.sv
// Request, adder and result signals for ksa28_share_ctrl.
// master = FP control / adder side, slave = the sharing controller.
interface ksa28_share_ctrl_if #(
  parameter int WIDTH = 28,
  parameter int ID_W  = 1
);
  logic             rq0_valid;
  logic [WIDTH-1:0] rq0_a;
  logic [WIDTH-1:0] rq0_b;
  logic             rq0_sub;
  logic             rq0_ready;
  logic             rq1_valid;
  logic [WIDTH-1:0] rq1_a;
  logic [WIDTH-1:0] rq1_b;
  logic             rq1_sub;
  logic             rq1_ready;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             res_valid;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;
  logic [ID_W-1:0]  res_id;
  logic             res_ready;

  modport master (
    output rq0_valid, rq0_a, rq0_b, rq0_sub,
    input  rq0_ready,
    output rq1_valid, rq1_a, rq1_b, rq1_sub,
    input  rq1_ready,
    input  add_a, add_b, add_cin,
    output add_sum, add_cout,
    input  res_valid, res_sum, res_cout, res_id,
    output res_ready
  );

  modport slave (
    input  rq0_valid, rq0_a, rq0_b, rq0_sub,
    output rq0_ready,
    input  rq1_valid, rq1_a, rq1_b, rq1_sub,
    output rq1_ready,
    output add_a, add_b, add_cin,
    input  add_sum, add_cout,
    output res_valid, res_sum, res_cout, res_id,
    input  res_ready
  );
endinterface

// File: rtl/ksa28_share_ctrl.sv
// Two-port sharing controller for one 28-bit Kogge-Stone adder.
// Define KSA28_FIXED_PRIO_EN for fixed priority (port 0 wins ties).
module ksa28_share_ctrl #(
  parameter int WIDTH = 28,
  parameter int ID_W  = 1
) (
  input logic                clk,
  input logic                rst_n,
  ksa28_share_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  state_t           state;
  logic [ID_W-1:0]  tag;
  logic             hs;
  logic             gnt_ok;
  logic             win;
  logic             acc;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_sub;
`ifndef KSA28_FIXED_PRIO_EN
  logic             rr_last;
  logic             both;
`endif

  // Arbitration and combinational grant; ready gated by reset
  always_comb begin
    hs     = bus.res_valid & bus.res_ready;
    gnt_ok = rst_n & ((state == IDLE) | ((state == DONE) & hs));
`ifdef KSA28_FIXED_PRIO_EN
    win    = !bus.rq0_valid;
`else
    both   = bus.rq0_valid & bus.rq1_valid;
    win    = both ? !rr_last : bus.rq1_valid;
`endif
    bus.rq0_ready = gnt_ok & bus.rq0_valid & !win;
    bus.rq1_ready = gnt_ok & bus.rq1_valid & win;
    acc    = bus.rq0_ready | bus.rq1_ready;
    op_a   = win ? bus.rq1_a : bus.rq0_a;
    op_b   = win ? bus.rq1_b : bus.rq0_b;
    op_sub = win ? bus.rq1_sub : bus.rq0_sub;
  end

  // Control FSM with registered adder drive and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      tag           <= '0;
      bus.add_a     <= '0;
      bus.add_b     <= '0;
      bus.add_cin   <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_sum   <= '0;
      bus.res_cout  <= 1'b0;
      bus.res_id    <= '0;
`ifndef KSA28_FIXED_PRIO_EN
      rr_last       <= 1'b1;
`endif
    end else begin
      if (acc) begin
        bus.add_a   <= op_a;
        bus.add_b   <= op_sub ? ~op_b : op_b;
        bus.add_cin <= op_sub;
        tag         <= ID_W'(win);
`ifndef KSA28_FIXED_PRIO_EN
        rr_last     <= win;
`endif
      end
      unique case (state)
        IDLE: begin
          if (acc) state <= EXEC;
        end
        EXEC: begin
          bus.res_sum   <= bus.add_sum;
          bus.res_cout  <= bus.add_cout;
          bus.res_id    <= tag;
          bus.res_valid <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          if (hs) begin
            bus.res_valid <= 1'b0;
            state         <= acc ? EXEC : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ksa28_share_ctrl.sv
// Directed bench for ksa28_share_ctrl with a behavioural adder.
// Vector table plus contention, backpressure and reset sequences.
module tb_ksa28_share_ctrl;

  localparam int W = 28;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  ksa28_share_ctrl_if #(.WIDTH(W), .ID_W(1)) bus ();

  ksa28_share_ctrl #(.WIDTH(W), .ID_W(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External adder model
  always_comb begin
    {bus.add_cout, bus.add_sum} =
      {1'b0, bus.add_a} + {1'b0, bus.add_b} + 29'(bus.add_cin);
  end

  typedef struct {
    logic         port;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] exp_b;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  vec_t vt [6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic port, input logic v,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub);
    if (port) begin
      bus.rq1_valid = v; bus.rq1_a = a;
      bus.rq1_b = b; bus.rq1_sub = sub;
    end else begin
      bus.rq0_valid = v; bus.rq0_a = a;
      bus.rq0_b = b; bus.rq0_sub = sub;
    end
  endtask

  task automatic wait_res(input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (bus.res_valid) seen = 1'b1;
    end
    chk(name, {31'd0, seen}, 32'd1);
  endtask

  int gnt[$];
  int rid[$];
  int rcyc[$];
  logic [W-1:0] hold_sum;

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.res_ready = 1'b1;
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    drive(1'b1, 1'b0, '0, '0, 1'b0);

    vt[0] = '{1'b0, 28'h0000005, 28'h0000003, 1'b0,
              28'h0000003, 28'h0000008, 1'b0};
    vt[1] = '{1'b1, 28'h0000005, 28'h0000003, 1'b1,
              28'hFFFFFFC, 28'h0000002, 1'b1};
    vt[2] = '{1'b1, 28'h0000003, 28'h0000005, 1'b1,
              28'hFFFFFFA, 28'hFFFFFFE, 1'b0};
    vt[3] = '{1'b0, 28'hFFFFFFF, 28'h0000001, 1'b0,
              28'h0000001, 28'h0000000, 1'b1};
    vt[4] = '{1'b0, 28'h8000000, 28'h8000000, 1'b1,
              28'h7FFFFFF, 28'h0000000, 1'b1};
    vt[5] = '{1'b1, 28'h0000000, 28'h0000001, 1'b1,
              28'hFFFFFFE, 28'hFFFFFFF, 1'b0};

    #12;
    @(negedge clk);
    chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("rst_add_b", {4'd0, bus.add_b}, 32'd0);
    chk("rst_res_sum", {4'd0, bus.res_sum}, 32'd0);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      drive(vt[i].port, 1'b1, vt[i].a, vt[i].b, vt[i].sub);
      @(negedge clk);
      chk($sformatf("v%0d_ready", i),
          {30'd0, bus.rq1_ready, bus.rq0_ready},
          vt[i].port ? 32'd2 : 32'd1);
      @(posedge clk); #1;
      drive(vt[i].port, 1'b0, '0, '0, 1'b0);
      @(negedge clk);
      chk($sformatf("v%0d_add_b", i), {4'd0, bus.add_b},
          {4'd0, vt[i].exp_b});
      chk($sformatf("v%0d_cin", i), {31'd0, bus.add_cin},
          {31'd0, vt[i].sub});
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), {31'd0, bus.res_valid}, 32'd1);
      chk($sformatf("v%0d_sum", i), {4'd0, bus.res_sum},
          {4'd0, vt[i].exp_sum});
      chk($sformatf("v%0d_cout", i), {31'd0, bus.res_cout},
          {31'd0, vt[i].exp_cout});
      chk($sformatf("v%0d_id", i), {31'd0, bus.res_id},
          {31'd0, vt[i].port});
    end

    // Contention from reset
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 28'd1, 28'd1, 1'b0);
    drive(1'b1, 1'b1, 28'd10, 28'd3, 1'b1);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (bus.rq0_ready && bus.rq1_ready)
        chk("both_ready", 32'd1, 32'd0);
      if (bus.rq0_ready) gnt.push_back(0);
      if (bus.rq1_ready) gnt.push_back(1);
      if (bus.res_valid) begin
        rid.push_back(int'(bus.res_id));
        rcyc.push_back(c);
      end
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    drive(1'b1, 1'b0, '0, '0, 1'b0);
    chk("cont_ngnt", {31'd0, gnt.size() >= 4}, 32'd1);
    chk("cont_nres", {31'd0, rid.size() >= 4}, 32'd1);
    if (gnt.size() >= 4 && rid.size() >= 4) begin
      for (int g = 0; g < 4; g++) begin
`ifdef KSA28_FIXED_PRIO_EN
        chk($sformatf("cont_gnt%0d", g), gnt[g], 32'd0);
        chk($sformatf("cont_rid%0d", g), rid[g], 32'd0);
`else
        chk($sformatf("cont_gnt%0d", g), gnt[g], g % 2);
        chk($sformatf("cont_rid%0d", g), rid[g], g % 2);
`endif
      end
      for (int g = 1; g < 4; g++)
        chk($sformatf("cont_gap%0d", g), rcyc[g] - rcyc[g-1], 32'd2);
    end
    repeat (4) @(posedge clk);
    #1;

    // Backpressure with a pending request
    bus.res_ready = 1'b0;
    drive(1'b0, 1'b1, 28'h1234567, 28'h0000111, 1'b0);
    @(negedge clk);
    chk("bp_acc", {31'd0, bus.rq0_ready}, 32'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    wait_res("bp_wait");
    hold_sum = bus.res_sum;
    chk("bp_sum", {4'd0, hold_sum}, 32'h1234678);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 28'd7, 28'd2, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d", c),
          {bus.res_valid, 3'd0, bus.res_sum},
          {1'b1, 3'd0, hold_sum});
      chk($sformatf("bp_id%0d", c), {31'd0, bus.res_id}, 32'd0);
      chk($sformatf("bp_rdy%0d", c),
          {30'd0, bus.rq1_ready, bus.rq0_ready}, 32'd0);
    end
    @(posedge clk); #1;
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_rdy", {31'd0, bus.rq1_ready}, 32'd1);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    chk("bp_clr", {31'd0, bus.res_valid}, 32'd0);
    @(negedge clk);
    chk("bp2_valid", {31'd0, bus.res_valid}, 32'd1);
    chk("bp2_sum", {4'd0, bus.res_sum}, 32'd5);
    chk("bp2_cout", {31'd0, bus.res_cout}, 32'd1);
    chk("bp2_id", {31'd0, bus.res_id}, 32'd1);

    // Reset during EXEC
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 28'd1, 28'd1, 1'b0);
    @(negedge clk);
    chk("rm_acc", {31'd0, bus.rq0_ready}, 32'd1);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 28'd2, 28'd2, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rm_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("rm_add", {3'd0, bus.add_cin, bus.add_a | bus.add_b}, 32'd0);
    chk("rm_rdy", {30'd0, bus.rq1_ready, bus.rq0_ready}, 32'd0);
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    drive(1'b1, 1'b0, '0, '0, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("rm_noval%0d", c), {31'd0, bus.res_valid}, 32'd0);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 28'd4, 28'd4, 1'b0);
    drive(1'b1, 1'b1, 28'd5, 28'd5, 1'b0);
    @(negedge clk);
    chk("rm_tie", {30'd0, bus.rq1_ready, bus.rq0_ready}, 32'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    drive(1'b1, 1'b0, '0, '0, 1'b0);
    wait_res("rm_wait");
    chk("rm_sum", {4'd0, bus.res_sum}, 32'd8);
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
